ws2812_rx: RTL and testbench
============================

// Module: ws2812_rx
// PURPOSE
//  Receives and decodes a WS2812 single-wire serial stream, i.e. the controller-to-LED direction, into per-pixel writes.
//  Output port names and widths match strip_ws2812's pixel_*_i / led_address_*_i inputs, so a decoded
//  stream can be stored directly in a pixel RAM. Used for daisy-chain input, bridging and loop-back of ws2812 outputs.
// PARAMETERS
//  LED_COUNT     512   pixels accepted per frame (1..512); later pixels produce no write
//  REVERSE       0     1: address = LED_COUNT-1-index; 0: address = index
//  BIT_THRESHOLD 12    high-pulse cycles; high_cnt >= BIT_THRESHOLD decodes '1', else '0' (20 MHz: T0H=8, T1H=16)
//  RESET_CYCLES  1000  low cycles that end a frame (50 us at 20 MHz); also the stuck-high limit
// PORTS
//  led_clk_i           in   1  sole clock; all logic on rising edge
//  rst_i               in   1  synchronous, active-high reset
//  led_data_i          in   1  asynchronous serial input
//  pixel_r_o           out  8  decoded red, valid with led_address_valid_o
//  pixel_g_o           out  8  decoded green
//  pixel_b_o           out  8  decoded blue
//  led_address_o       out  9  pixel address
//  led_address_valid_o out  1  one-cycle write strobe
//  frame_done_o        out  1  one-cycle pulse at reset-gap detection after >=1 bit
//  frame_error_o       out  1  one-cycle pulse: partial pixel at gap, or stuck-high
//  led_data_o          out  1  forwarded stream (see CONFIGURATION); 0 when macro absent
// BEHAVIOUR
//  - Reset: all outputs 0, state SYNC, counters 0, shift register 0, fwd gate 0.
//  - led_data_i passes a 2-flop synchronizer, then a registered copy feeds the edge detector.
//    Edges act 3 cycles after the pin changes.
//  - Cnt counts cycles since last edge, cleared on each edge, saturates at RESET_CYCLES.
//  - SYNC: ignore data; low for RESET_CYCLES -> READY. Never decodes a frame joined mid-stream.
//  - READY: rise -> HIGH; bit_idx=0, pix_idx=0.
//  - HIGH: fall -> shift in (cnt>=BIT_THRESHOLD), MSB first, and go to LOW.
//    If cnt reaches RESET_CYCLES while still high -> frame_error_o pulse, go to SYNC.
//  - LOW: rise -> HIGH. If cnt reaches RESET_CYCLES -> READY; frame_done_o pulses if any bit was received.
//    If bit_idx!=0 at that point, frame_error_o also pulses and the partial pixel is dropped.
//  - Wire order is G[7:0],R[7:0],B[7:0]. On the 24th bit, bit_idx wraps to 0.
//    If pix_idx<LED_COUNT, the next cycle raises led_address_valid_o for exactly 1 cycle,
//    with the address and RGB held stable that cycle; pix_idx then increments.
//    pix_idx saturates at LED_COUNT; pixel LED_COUNT and beyond: no strobe, no error.
//  - Latency: falling edge of the 24th bit on the pin -> strobe = 5 cycles.
//  - A new frame always restarts at address index 0.
//  - Reset mid-frame: immediate return to SYNC; no strobe or pulse is emitted for the aborted frame.
// CONFIGURATION
//  `WS2812_RX_FORWARD_EN defined:
//    - Fwd gate sets in the cycle pix_idx reaches LED_COUNT; it clears on the frame gap, on stuck-high, and on reset.
//    - led_data_o = sync_data & gate, registered: 1 cycle after the edge-detector copy, 4 cycles after the pin.
//    - The gate only opens while the line is low, so no runt pulse is generated.
//    - Downstream strips see only pixels beyond LED_COUNT.
//  Macro absent: led_data_o tied 0, no gate logic.
// STRUCTURE
//  - ws2812_pkg: state enum (SYNC, READY, HIGH, LOW), BITS_PER_PIXEL=24, default timing constants.
//  - Sub-module ws2812_rx_edge: synchronizer + rise/fall pulses + registered level.
//  - Top level: the state machine, cnt, shifter, pix_idx and the forward gate.
// TESTING
//  1 Gap of 1000 low cycles, then 1 pixel 0x00FF80 with T1H=16/T0H=8/period=25, then gap
//     -> 1 strobe: addr 0, g=00 r=FF b=80; then frame_done_o.
//  2 LED_COUNT=4, 6 pixels sent -> strobes for addr 0..3 only.
//     With REVERSE=1 -> addr 3,2,1,0. With macro, led_data_o replays pixels 4,5 bit-exact.
//  3 Stream begins mid-frame without a preceding gap -> no strobe until a full gap, then normal decode.
//  4 Gap after 10 bits -> frame_error_o and frame_done_o pulse together, no strobe.
//     The next frame decodes from address 0.
//  5 Line high for 1000 cycles -> frame_error_o pulse, SYNC; a later gap + frame decodes correctly.
//  6 rst_i asserted at bit 12 of pixel 2 -> all outputs 0 next cycle.
//     No strobe for pixel 2; the next gap + frame starts at address 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 receiver.
// Optional forwarding output is enabled with `WS2812_RX_FORWARD_EN.
package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    READY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } rx_state_e;

  localparam int BITS_PER_PIXEL    = 24;
  localparam int DEF_LED_COUNT     = 512;
  localparam int DEF_BIT_THRESHOLD = 12;
  localparam int DEF_RESET_CYCLES  = 1000;

endpackage

// File: rtl/ws2812_rx_edge.sv
// Input synchronizer for the WS2812 line: 2-flop sync, registered level
// and registered rise/fall pulses aligned with that level.
module ws2812_rx_edge (
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync1_d = data_i;
    sync2_d = sync1_q;
    level_d = sync2_q;
    rise_d  = sync2_q & ~level_q;
    fall_d  = ~sync2_q & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 stream decoder producing per-pixel write strobes.
// `WS2812_RX_FORWARD_EN adds led_data_o forwarding of pixels beyond LED_COUNT.
//
// state | meaning
// SYNC  | waiting for a full reset gap; line activity ignored
// READY | gap seen, waiting for first rising edge of a frame
// HIGH  | inside the high phase of a bit
// LOW   | inside the low phase of a bit, or trailing gap
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int LED_COUNT     = DEF_LED_COUNT,
  parameter int REVERSE       = 0,
  parameter int BIT_THRESHOLD = DEF_BIT_THRESHOLD,
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES
) (
  input  logic       led_clk_i,
  input  logic       rst_i,
  input  logic       led_data_i,
  output logic [7:0] pixel_r_o,
  output logic [7:0] pixel_g_o,
  output logic [7:0] pixel_b_o,
  output logic [8:0] led_address_o,
  output logic       led_address_valid_o,
  output logic       frame_done_o,
  output logic       frame_error_o,
  output logic       led_data_o
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] CNT_THR   = CW'(BIT_THRESHOLD);
  localparam logic [9:0]    PIX_LIMIT = 10'(LED_COUNT);
  localparam logic [8:0]    ADDR_LAST = 9'(LED_COUNT - 1);
  localparam logic [4:0]    BIT_LAST  = 5'(BITS_PER_PIXEL - 1);

  logic level, rise, fall;

  ws2812_rx_edge u_edge (
    .clk    (led_clk_i),
    .rst    (rst_i),
    .data_i (led_data_i),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [9:0]  pix_idx_q, pix_idx_d;
  logic [23:0] shift_q, shift_d;
  logic        pend_q, pend_d;
  logic        got_bit_q, got_bit_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [8:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        gap_end, stuck_high;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    pix_idx_d  = pix_idx_q;
    shift_d    = shift_q;
    got_bit_d  = got_bit_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    addr_d     = addr_q;
    pend_d     = 1'b0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    gap_end    = 1'b0;
    stuck_high = 1'b0;

    if (rise || fall)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;

    // Pixel completed last cycle; shifter holds {G,R,B}.
    if (pend_q) begin
      g_d       = shift_q[23:16];
      r_d       = shift_q[15:8];
      b_d       = shift_q[7:0];
      addr_d    = (REVERSE != 0) ? (ADDR_LAST - pix_idx_q[8:0]) : pix_idx_q[8:0];
      valid_d   = 1'b1;
      pix_idx_d = pix_idx_q + 1'b1;
    end

    unique case (state_q)
      SYNC: begin
        if (!level && cnt_q == CNT_MAX) state_d = READY;
      end
      READY: begin
        if (rise) begin
          state_d   = HIGH;
          bit_idx_d = '0;
          pix_idx_d = '0;
          got_bit_d = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          shift_d   = {shift_q[22:0], (cnt_q >= CNT_THR)};
          got_bit_d = 1'b1;
          state_d   = LOW;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            pend_d    = (pix_idx_q < PIX_LIMIT);
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          err_d      = 1'b1;
          stuck_high = 1'b1;
          state_d    = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = READY;
          gap_end = 1'b1;
          done_d  = got_bit_q;
          err_d   = (bit_idx_q != '0);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge led_clk_i) begin
    if (rst_i) begin
      state_q   <= SYNC;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      pix_idx_q <= '0;
      shift_q   <= '0;
      pend_q    <= 1'b0;
      got_bit_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      pix_idx_q <= pix_idx_d;
      shift_q   <= shift_d;
      pend_q    <= pend_d;
      got_bit_q <= got_bit_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign pixel_r_o           = r_q;
  assign pixel_g_o           = g_q;
  assign pixel_b_o           = b_q;
  assign led_address_o       = addr_q;
  assign led_address_valid_o = valid_q;
  assign frame_done_o        = done_q;
  assign frame_error_o       = err_q;

`ifdef WS2812_RX_FORWARD_EN
  logic gate_q, gate_d;
  logic fwd_q, fwd_d;

  // The gate opens right after a strobe, i.e. while the line is low.
  always_comb begin
    gate_d = gate_q;
    if (pend_q && (pix_idx_q + 1'b1) == PIX_LIMIT) gate_d = 1'b1;
    if (gap_end || stuck_high) gate_d = 1'b0;
    fwd_d = level & gate_q;
  end

  always_ff @(posedge led_clk_i) begin
    if (rst_i) begin
      gate_q <= 1'b0;
      fwd_q  <= 1'b0;
    end else begin
      gate_q <= gate_d;
      fwd_q  <= fwd_d;
    end
  end

  assign led_data_o = fwd_q;
`else
  assign led_data_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: two instances (LED_COUNT=4, forward and reversed addressing).
// Optional checks for led_data_o when WS2812_RX_FORWARD_EN is defined.
module tb_ws2812_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [8:0] a0, a1;
  logic       v0, d0, e0, f0, v1, d1, e1, f1;

  always #5 clk = ~clk;

  ws2812_rx #(.LED_COUNT(4), .REVERSE(0)) dut (
    .led_clk_i(clk), .rst_i(rst), .led_data_i(din),
    .pixel_r_o(r0), .pixel_g_o(g0), .pixel_b_o(b0),
    .led_address_o(a0), .led_address_valid_o(v0),
    .frame_done_o(d0), .frame_error_o(e0), .led_data_o(f0)
  );

  ws2812_rx #(.LED_COUNT(4), .REVERSE(1)) dut_rev (
    .led_clk_i(clk), .rst_i(rst), .led_data_i(din),
    .pixel_r_o(r1), .pixel_g_o(g1), .pixel_b_o(b1),
    .led_address_o(a1), .led_address_valid_o(v1),
    .frame_done_o(d1), .frame_error_o(e1), .led_data_o(f1)
  );

  typedef struct {
    bit         is_pix;
    logic [8:0] addr;
    logic [23:0] grb;
    bit         done;
    bit         err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_event(input string name, input exp_t x, input logic v, input logic d,
                           input logic e, input logic [8:0] a, input logic [23:0] grb);
    check({name, " kind{v,done,err}"}, {29'd0, v, d, e}, {29'd0, x.is_pix, x.done, x.err});
    if (x.is_pix) begin
      check({name, " addr"}, {23'd0, a}, {23'd0, x.addr});
      check({name, " grb"}, {8'd0, grb}, {8'd0, x.grb});
    end
  endtask

  // Monitor: pops one expectation per DUT output event.
  always @(negedge clk) begin
    if (!rst) begin
      if (v0 || d0 || e0) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut unexpected output: v=%0b done=%0b err=%0b addr=%0d, none required", v0, d0, e0, a0);
        end else begin
          exp_t x;
          x = q0.pop_front();
          cmp_event("dut", x, v0, d0, e0, a0, {g0, r0, b0});
        end
      end
      if (v1 || d1 || e1) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut_rev unexpected output: v=%0b done=%0b err=%0b addr=%0d, none required", v1, d1, e1, a1);
        end else begin
          exp_t x;
          x = q1.pop_front();
          cmp_event("dut_rev", x, v1, d1, e1, a1, {g1, r1, b1});
        end
      end
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  bit fwd_exp[$];
  int fwd_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (f0) fwd_run++;
      else if (fwd_run > 0) begin
        if (fwd_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL fwd unexpected pulse of %0d cycles, none required", fwd_run);
        end else begin
          bit eb;
          eb = fwd_exp.pop_front();
          check("fwd pulse width", fwd_run, eb ? 32'd16 : 32'd8);
        end
        fwd_run = 0;
      end
    end
  end
`else
  bit fwd_seen = 1'b0;
  always @(negedge clk) if (f0 || f1) fwd_seen = 1'b1;
`endif

  task automatic send_bit(input bit b);
    din = 1'b1;
    repeat (b ? 16 : 8) @(negedge clk);
    din = 1'b0;
    repeat (b ? 9 : 17) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_pixel(input logic [23:0] w, input int idx);
    exp_t x;
    if (idx < 4) begin
      x = '{is_pix: 1'b1, addr: 9'(idx), grb: w, done: 1'b0, err: 1'b0};
      q0.push_back(x);
      x.addr = 9'(3 - idx);
      q1.push_back(x);
    end
`ifdef WS2812_RX_FORWARD_EN
    else begin
      for (int i = 23; i >= 0; i--) fwd_exp.push_back(w[i]);
    end
`endif
    send_bits(w, 24);
  endtask

  task automatic expect_frame(input bit done, input bit err);
    exp_t x;
    x = '{is_pix: 1'b0, addr: 9'd0, grb: 24'd0, done: done, err: err};
    q0.push_back(x);
    q1.push_back(x);
  endtask

  task automatic gap();
    din = 1'b0;
    repeat (1100) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " dut outputs"}, {v0, d0, e0, f0, a0, g0, r0, b0}, 37'd0);
    check({name, " dut_rev outputs"}, {v1, d1, e1, f1, a1, g1, r1, b1}, 37'd0);
  endtask

  logic [23:0] frame2 [6];

  initial begin
    frame2[0] = 24'h123456; frame2[1] = 24'hABCDEF; frame2[2] = 24'h0F0F0F;
    frame2[3] = 24'hF0F0F0; frame2[4] = 24'h5A5AA5; frame2[5] = 24'hC3C33C;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Joined mid-stream: no gap yet, nothing may be decoded.
    send_bits(24'hA5C3F0, 24);
    send_bits(24'h3C0000, 6);
    gap();

    send_pixel(24'h00FF80, 0);
    expect_frame(1'b1, 1'b0);
    gap();

    for (int i = 0; i < 6; i++) send_pixel(frame2[i], i);
    expect_frame(1'b1, 1'b0);
    gap();

    // Partial pixel at the gap.
    send_bits(24'hB2C000, 10);
    expect_frame(1'b1, 1'b1);
    gap();
    send_pixel(24'h112233, 0);
    expect_frame(1'b1, 1'b0);
    gap();

    // Stuck-high line.
    expect_frame(1'b0, 1'b1);
    din = 1'b1;
    repeat (1100) @(negedge clk);
    din = 1'b0;
    gap();
    send_pixel(24'h445566, 0);
    expect_frame(1'b1, 1'b0);
    gap();

    // Reset in the middle of pixel 2.
    send_pixel(24'hDEAD01, 0);
    send_pixel(24'hBEEF02, 1);
    send_bits(24'hFFF000, 12);
    rst = 1'b1;
    @(posedge clk);
    #1 check_all_zero("mid-frame reset");
    @(negedge clk) rst = 1'b0;
    gap();
    send_pixel(24'h778899, 0);
    expect_frame(1'b1, 1'b0);
    gap();

    repeat (20) @(negedge clk);
    check("dut pending expectations", q0.size(), 32'd0);
    check("dut_rev pending expectations", q1.size(), 32'd0);
`ifdef WS2812_RX_FORWARD_EN
    check("fwd pending bits", fwd_exp.size(), 32'd0);
`else
    check("led_data_o idle", {31'd0, fwd_seen}, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
